// File: rtl/code_lock_n.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_n
// Brief    : Keypad code lock with retry lockout, reprogramming and 7-seg display.
// Revision : 1.0
// ============================================================================
module code_lock_n #(
    parameter int                    DIGITS       = 4,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE = 16'h2601,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    LOCKOUT_CYC  = 1000,
    parameter int                    UNLOCK_CYC   = 500
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         key,
    input  logic                               enter,
    input  logic                               clear,
    input  logic                               prog,
    output logic                               unlock,
    output logic                               lockout,
    output logic                               prog_mode,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
    output logic [7*DIGITS-1:0]                seg
);

    localparam int c_CNT_W   = $clog2(DIGITS + 1);
    localparam int c_FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int c_TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_FULL        = c_CNT_W'(DIGITS);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX    = c_FAIL_W'(MAX_TRIES);
    localparam logic [c_TMR_W-1:0]  c_UNLOCK_LAST = c_TMR_W'(UNLOCK_CYC - 1);
    localparam logic [c_TMR_W-1:0]  c_LOCK_LAST   = c_TMR_W'(LOCKOUT_CYC - 1);

    localparam logic [6:0] c_SEG_DASH = 7'b1111110;
    localparam logic [6:0] c_SEG_U    = 7'b1000001;
    localparam logic [6:0] c_SEG_L    = 7'b1110001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_FULL  = 3'd2,
        S_OPEN  = 3'd3,
        S_PROG  = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    state_t                      r_state, w_state_n;
    logic [c_CNT_W-1:0]          r_cnt, w_cnt_n;
    logic [DIGITS-1:0][3:0]      r_buf, w_buf_n;
    logic [c_FAIL_W-1:0]         r_fail, w_fail_n;
    logic [4*DIGITS-1:0]         r_code, w_code_n;
    logic [c_TMR_W-1:0]          r_tmr, w_tmr_n;
    logic [9:0]                  r_key;

    logic                        w_key_evt;
    logic [3:0]                  w_digit;
    logic                        w_match;
    logic [c_FAIL_W-1:0]         w_fail_inc;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    f_glyph = 7'b0000001;
            4'd1:    f_glyph = 7'b1001111;
            4'd2:    f_glyph = 7'b0010010;
            4'd3:    f_glyph = 7'b0000110;
            4'd4:    f_glyph = 7'b1001100;
            4'd5:    f_glyph = 7'b0100100;
            4'd6:    f_glyph = 7'b0100000;
            4'd7:    f_glyph = 7'b0001111;
            4'd8:    f_glyph = 7'b0000000;
            4'd9:    f_glyph = 7'b0000100;
            default: f_glyph = c_SEG_DASH;
        endcase
    endfunction

    // A press counts only when the keypad was idle last cycle and exactly one key is down now.
    assign w_key_evt  = (r_key == 10'd0) && $onehot(key);
    assign w_fail_inc = r_fail + c_FAIL_W'(1);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) w_digit = 4'(i);
        end
    end

    // Buffer slot 0 holds the first digit entered, matching the code's top nibble.
    always_comb begin
        w_match = (r_cnt == c_FULL);
        for (int i = 0; i < DIGITS; i++) begin
            if (r_code[4*(DIGITS-1-i) +: 4] != r_buf[i]) w_match = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_fail  <= '0;
            r_code  <= DEFAULT_CODE;
            r_tmr   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_buf   <= w_buf_n;
            r_fail  <= w_fail_n;
            r_code  <= w_code_n;
            r_tmr   <= w_tmr_n;
            r_key   <= key;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_buf_n   = r_buf;
        w_fail_n  = r_fail;
        w_code_n  = r_code;
        w_tmr_n   = '0;

        case (r_state)
            S_IDLE, S_ENTRY, S_FULL, S_PROG: begin
                if (clear) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                    w_buf_n   = '0;
                end else if (enter) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                    w_buf_n   = '0;
                    if (r_state == S_PROG) begin
                        if (r_cnt == c_FULL) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                w_code_n[4*(DIGITS-1-i) +: 4] = r_buf[i];
                            end
                        end
                    end else if (w_match) begin
                        w_state_n = S_OPEN;
                        w_fail_n  = '0;
                    end else begin
                        w_fail_n = w_fail_inc;
                        if (w_fail_inc == c_FAIL_MAX) w_state_n = S_LOCK;
                    end
                end else if (w_key_evt && (r_cnt != c_FULL)) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_cnt == c_CNT_W'(i)) w_buf_n[i] = w_digit;
                    end
                    w_cnt_n = r_cnt + c_CNT_W'(1);
                    if (r_state != S_PROG) begin
                        w_state_n = (w_cnt_n == c_FULL) ? S_FULL : S_ENTRY;
                    end
                end
            end
            S_OPEN: begin
                if (clear || enter) begin
                    w_state_n = S_IDLE;
                end else if (prog) begin
                    w_state_n = S_PROG;
                end else if (r_tmr == c_UNLOCK_LAST) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_tmr_n = r_tmr + c_TMR_W'(1);
                end
            end
            S_LOCK: begin
                if (r_tmr == c_LOCK_LAST) begin
                    w_state_n = S_IDLE;
                    w_fail_n  = '0;
                end else begin
                    w_tmr_n = r_tmr + c_TMR_W'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
                w_buf_n   = '0;
            end
        endcase
    end

    assign unlock    = (r_state == S_OPEN);
    assign lockout   = (r_state == S_LOCK);
    assign prog_mode = (r_state == S_PROG);
    assign fail_cnt  = r_fail;

    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            case (r_state)
                S_OPEN:  seg[7*i +: 7] = c_SEG_U;
                S_LOCK:  seg[7*i +: 7] = c_SEG_L;
                default: seg[7*i +: 7] = (c_CNT_W'(i) < r_cnt) ? f_glyph(r_buf[i]) : c_SEG_DASH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_code_lock_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_n
// Brief    : Directed table-driven and sequence checks for code_lock_n.
// Revision : 1.0
// ============================================================================
module tb_code_lock_n;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                           G3 = 7'b0000110, G6 = 7'b0100000, G7 = 7'b0001111,
                           G8 = 7'b0000000, G9 = 7'b0000100;
    localparam logic [6:0] D  = 7'b1111110, GU = 7'b1000001, GL = 7'b1110001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  key = '0;
    logic        enter = 1'b0, clear = 1'b0, prog = 1'b0;
    logic        unlock, lockout, prog_mode;
    logic [1:0]  fail_cnt;
    logic [27:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    code_lock_n #(
        .DIGITS(4), .DEFAULT_CODE(16'h2601), .MAX_TRIES(3),
        .LOCKOUT_CYC(8), .UNLOCK_CYC(5)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .enter(enter), .clear(clear), .prog(prog),
        .unlock(unlock), .lockout(lockout), .prog_mode(prog_mode),
        .fail_cnt(fail_cnt), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  key;
        logic        enter;
        logic        clear;
        logic        prog;
        logic        unlock;
        logic        lockout;
        logic        prog_mode;
        logic [1:0]  fail;
        logic [27:0] seg;
    } vec_t;

    vec_t vecs[14];

    // Field 0 (leftmost) occupies the low bits.
    function automatic logic [27:0] s4(input logic [6:0] f0, f1, f2, f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        key = '0;
        key[d] = 1'b1;
        tick();
        key = '0;
        tick();
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press(int'(c[15-4*i -: 4]));
        pulse_enter();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{key:10'b0000000100, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,D,D,D)};
        vecs[1]  = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,D,D,D)};
        vecs[2]  = '{key:10'b0001000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,D,D)};
        vecs[3]  = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,D,D)};
        vecs[4]  = '{key:10'b0000000001, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,G0,D)};
        vecs[5]  = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,G0,D)};
        vecs[6]  = '{key:10'b0000000010, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,G0,G1)};
        vecs[7]  = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(G2,G6,G0,G1)};
        vecs[8]  = '{key:10'b0000000000, enter:1, clear:0, prog:0, unlock:1, lockout:0, prog_mode:0, fail:0, seg:s4(GU,GU,GU,GU)};
        vecs[9]  = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:1, lockout:0, prog_mode:0, fail:0, seg:s4(GU,GU,GU,GU)};
        vecs[10] = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:1, lockout:0, prog_mode:0, fail:0, seg:s4(GU,GU,GU,GU)};
        vecs[11] = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:1, lockout:0, prog_mode:0, fail:0, seg:s4(GU,GU,GU,GU)};
        vecs[12] = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:1, lockout:0, prog_mode:0, fail:0, seg:s4(GU,GU,GU,GU)};
        vecs[13] = '{key:10'b0000000000, enter:0, clear:0, prog:0, unlock:0, lockout:0, prog_mode:0, fail:0, seg:s4(D,D,D,D)};

        // Reset state
        repeat (2) tick();
        chk("reset_flags", {unlock, lockout, prog_mode, fail_cnt}, '0);
        chk("reset_seg", seg, s4(D,D,D,D));
        rst = 1'b0;
        tick();

        // Correct code opens for exactly five cycles
        for (int v = 0; v < 14; v++) begin
            key = vecs[v].key; enter = vecs[v].enter; clear = vecs[v].clear; prog = vecs[v].prog;
            tick();
            chk($sformatf("vec%0d", v), {unlock, lockout, prog_mode, fail_cnt, seg},
                {vecs[v].unlock, vecs[v].lockout, vecs[v].prog_mode, vecs[v].fail, vecs[v].seg});
        end
        key = '0; enter = 0; clear = 0; prog = 0;

        // Three failures lead to lockout
        enter_code(16'h1111);
        chk("fail1", fail_cnt, 1);
        enter_code(16'h1111);
        chk("fail2", fail_cnt, 2);
        enter_code(16'h1111);
        chk("lock_flag", {lockout, unlock, fail_cnt}, {1'b1, 1'b0, 2'd3});
        chk("lock_seg", seg, s4(GL,GL,GL,GL));
        key = 10'b0000000100; tick();
        key = '0;             tick();
        key = 10'b0001000000; tick();
        key = '0;             tick();
        key = 10'b0000000001; tick();
        key = '0;             tick();
        key = 10'b0000000010; enter = 1'b1; tick();
        chk("lock_hold7", {lockout, unlock, seg}, {1'b1, 1'b0, s4(GL,GL,GL,GL)});
        key = '0; enter = 1'b0; tick();
        chk("lock_exit", {lockout, unlock, fail_cnt}, {1'b0, 1'b0, 2'd0});
        chk("lock_exit_seg", seg, s4(D,D,D,D));

        // Short entry, held key, multi-key
        press(2); press(6); pulse_enter();
        chk("short_fail", fail_cnt, 1);
        chk("short_seg", seg, s4(D,D,D,D));
        key = 10'b0000001000;
        repeat (10) tick();
        key = '0; tick();
        chk("held_key", seg, s4(G3,D,D,D));
        key = 10'b0000011000; tick(); tick();
        key = '0; tick();
        chk("multi_key", seg, s4(G3,D,D,D));

        // Same-cycle key, clear and enter: clear wins
        key = 10'b0000100000; clear = 1'b1; enter = 1'b1; tick();
        key = '0; clear = 1'b0; enter = 1'b0;
        chk("prio_seg", seg, s4(D,D,D,D));
        chk("prio_fail", {fail_cnt, unlock, lockout}, {2'd1, 1'b0, 1'b0});
        tick();

        // Reprogramming
        enter_code(16'h2601);
        chk("open_again", {unlock, fail_cnt}, {1'b1, 2'd0});
        prog = 1'b1; tick(); prog = 1'b0;
        chk("prog_enter", {prog_mode, unlock, seg}, {1'b1, 1'b0, s4(D,D,D,D)});
        press(9); press(8); press(7); press(6);
        chk("prog_digits", seg, s4(G9,G8,G7,G6));
        pulse_enter();
        chk("prog_store", {prog_mode, seg}, {1'b0, s4(D,D,D,D)});
        enter_code(16'h2601);
        chk("old_code", {unlock, fail_cnt}, {1'b0, 2'd1});
        enter_code(16'h9876);
        chk("new_code", {unlock, fail_cnt}, {1'b1, 2'd0});
        clear = 1'b1; tick(); clear = 1'b0;
        chk("open_clear", unlock, 0);

        // Short programming entry aborts with code unchanged
        enter_code(16'h9876);
        prog = 1'b1; tick(); prog = 1'b0;
        press(5); pulse_enter();
        chk("prog_abort", prog_mode, 0);
        enter_code(16'h9876);
        chk("code_kept", unlock, 1);
        enter = 1'b1; tick(); enter = 1'b0;

        // Asynchronous reset mid-programming restores the default code
        enter_code(16'h9876);
        prog = 1'b1; tick(); prog = 1'b0;
        press(9); press(8);
        chk("prog_partial", {prog_mode, seg}, {1'b1, s4(G9,G8,D,D)});
        #2 rst = 1'b1;
        #2;
        chk("async_rst", {prog_mode, unlock, lockout, fail_cnt, seg}, {1'b0, 1'b0, 1'b0, 2'd0, s4(D,D,D,D)});
        #2 rst = 1'b0;
        tick();
        enter_code(16'h2601);
        chk("default_code", unlock, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
